// File: rtl/i2s_rx_param.sv
// ---------------------------------------------------------------------------
// i2s_rx_param
//   I2S / left-justified serial audio receiver that runs on the bit clock.
//   It deserialises stereo slots, MSB first, into left and right words. The
//   words are left-aligned. Bits beyond WORD_WIDTH are dropped, and a short
//   slot is zero-padded.
//
// Parameters
//   WORD_WIDTH : bits per output sample (8..32)
//   SLOT_WIDTH : nominal bck cycles per lrck half-period (>= 1)
//   FMT_LJ     : 0 = I2S (MSB one bck after the lrck edge),
//                1 = left-justified (MSB on the lrck edge)
//   CNT_W      : width of the slot-length error counter
//
// Ports
//   bck         in   serial bit clock; all logic runs on its posedge
//   rst         in   asynchronous reset, active-high
//   lrck        in   word select: 0 = left slot, 1 = right slot
//   din         in   serial data
//   l_dout      out  last completed left word
//   r_dout      out  last completed right word
//   l_valid     out  1-cycle pulse when l_dout updates
//   r_valid     out  1-cycle pulse when r_dout updates
//   frame_valid out  pulses with r_valid when a left word was committed
//                    since the previous r_valid
//
// Optional feature (macro I2S_RX_SLOT_CHECK_EN)
//   slot_err    out  pulses with a commit whose slot length != SLOT_WIDTH
//   err_cnt     out  saturating count of slot_err pulses
//   When the macro is undefined, these ports and the length check are absent.
// ---------------------------------------------------------------------------
module i2s_rx_param #(
  parameter int WORD_WIDTH = 24,
  parameter int SLOT_WIDTH = 32,
  parameter int FMT_LJ     = 0,
  parameter int CNT_W      = 8
) (
  input  logic                  bck,
  input  logic                  rst,
  input  logic                  lrck,
  input  logic                  din,
  output logic [WORD_WIDTH-1:0] l_dout,
  output logic [WORD_WIDTH-1:0] r_dout,
  output logic                  l_valid,
  output logic                  r_valid,
  output logic                  frame_valid
`ifdef I2S_RX_SLOT_CHECK_EN
  ,
  output logic                  slot_err,
  output logic [CNT_W-1:0]      err_cnt
`endif
);

  // bit_cnt must be able to count past both the word and the nominal slot.
  // A slot that is one bit too long then still differs from SLOT_WIDTH.
  localparam int MAX_LEN = (WORD_WIDTH > SLOT_WIDTH) ? WORD_WIDTH : SLOT_WIDTH;
  localparam int CW      = $clog2(MAX_LEN + 2);

  if (WORD_WIDTH < 8 || WORD_WIDTH > 32 || SLOT_WIDTH < 1 || CNT_W < 1) begin : g_param_chk
    $error("i2s_rx_param: parameter out of range");
  end

  logic                  lrck_q;
  logic                  edge_q;
  logic                  edge_now;
  logic                  start;
  logic                  chan;
  logic                  commit;
  logic [WORD_WIDTH-1:0] word;
  logic [CW-1:0]         bit_cnt;
  logic                  cur_chan;
  logic                  have_slot;
  logic                  have_left;

  // Slot start detection. In I2S the MSB arrives one bck after the edge, so
  // the start is the registered edge. The channel is the lrck value sampled
  // in the cycle of the edge.
  always_comb begin
    edge_now = lrck ^ lrck_q;
    start    = 1'b0;
    chan     = 1'b0;
    if (FMT_LJ != 0) begin
      start = edge_now;
      chan  = lrck;
    end else begin
      start = edge_q;
      chan  = lrck_q;
    end
    commit = start & have_slot;
  end

  // ---- capture stage: shift serial bits into the word being received ----
  always_ff @(posedge bck or posedge rst) begin
    if (rst) begin
      lrck_q    <= 1'b0;
      edge_q    <= 1'b0;
      word      <= '0;
      bit_cnt   <= '0;
      cur_chan  <= 1'b0;
      have_slot <= 1'b0;
    end else begin
      lrck_q <= lrck;
      edge_q <= edge_now;
      if (start) begin
        word      <= {din, {(WORD_WIDTH-1){1'b0}}};
        bit_cnt   <= CW'(1);
        cur_chan  <= chan;
        have_slot <= 1'b1;
      end else begin
        // Bit number bit_cnt lands at position WORD_WIDTH-1-bit_cnt. Bits
        // past the word width match no position and are dropped.
        for (int i = 0; i < WORD_WIDTH; i++) begin
          if (bit_cnt == CW'(WORD_WIDTH - 1 - i)) begin
            word[i] <= din;
          end
        end
        if (bit_cnt != '1) begin
          bit_cnt <= bit_cnt + CW'(1);
        end
      end
    end
  end

  // ---- commit stage: move the finished word to its channel output ----
  // The old word is read on the same edge that restarts capture, so the
  // commit and the new slot's MSB never conflict.
  always_ff @(posedge bck or posedge rst) begin
    if (rst) begin
      l_dout      <= '0;
      r_dout      <= '0;
      l_valid     <= 1'b0;
      r_valid     <= 1'b0;
      frame_valid <= 1'b0;
      have_left   <= 1'b0;
    end else begin
      l_valid     <= 1'b0;
      r_valid     <= 1'b0;
      frame_valid <= 1'b0;
      if (commit) begin
        if (!cur_chan) begin
          l_dout    <= word;
          l_valid   <= 1'b1;
          have_left <= 1'b1;
        end else begin
          r_dout      <= word;
          r_valid     <= 1'b1;
          frame_valid <= have_left;
          have_left   <= 1'b0;
        end
      end
    end
  end

`ifdef I2S_RX_SLOT_CHECK_EN
  logic len_err;

  // At a start, bit_cnt holds the length of the slot that is ending.
  always_comb begin
    len_err = (bit_cnt != CW'(SLOT_WIDTH));
  end

  always_ff @(posedge bck or posedge rst) begin
    if (rst) begin
      slot_err <= 1'b0;
      err_cnt  <= '0;
    end else begin
      slot_err <= commit & len_err;
      if (commit && len_err && (err_cnt != '1)) begin
        err_cnt <= err_cnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_i2s_rx_param.sv
// ---------------------------------------------------------------------------
// tb_i2s_rx_param
//   Two receivers share the same serial wires. dut_a is in I2S mode and
//   dut_b is in left-justified mode (with CNT_W=2). Each scenario builds a
//   wire pattern from a list of slots and records both receivers every
//   cycle. The recorded outputs are compared with a reference model. The
//   model finds slot starts directly from the recorded lrck/din streams.
// ---------------------------------------------------------------------------
module tb_i2s_rx_param;

  localparam int WW   = 24;
  localparam int SW   = 32;
  localparam int MAXN = 1200;

  logic bck = 1'b0;
  logic rst = 1'b0;
  logic lrck = 1'b0;
  logic din = 1'b0;

  logic [WW-1:0] l_dout_a, r_dout_a, l_dout_b, r_dout_b;
  logic          l_valid_a, r_valid_a, frame_valid_a;
  logic          l_valid_b, r_valid_b, frame_valid_b;
  logic          se_a_w, se_b_w;
  logic [7:0]    ec_a_w, ec_b_w;

`ifdef I2S_RX_SLOT_CHECK_EN
  logic       se_a, se_b;
  logic [7:0] ec_a;
  logic [1:0] ec_b;
  assign se_a_w = se_a;
  assign se_b_w = se_b;
  assign ec_a_w = ec_a;
  assign ec_b_w = {6'b0, ec_b};
`else
  assign se_a_w = 1'b0;
  assign se_b_w = 1'b0;
  assign ec_a_w = 8'd0;
  assign ec_b_w = 8'd0;
`endif

  i2s_rx_param #(.WORD_WIDTH(WW), .SLOT_WIDTH(SW), .FMT_LJ(0), .CNT_W(8)) dut_a (
    .bck(bck), .rst(rst), .lrck(lrck), .din(din),
    .l_dout(l_dout_a), .r_dout(r_dout_a),
    .l_valid(l_valid_a), .r_valid(r_valid_a), .frame_valid(frame_valid_a)
`ifdef I2S_RX_SLOT_CHECK_EN
    , .slot_err(se_a), .err_cnt(ec_a)
`endif
  );

  i2s_rx_param #(.WORD_WIDTH(WW), .SLOT_WIDTH(SW), .FMT_LJ(1), .CNT_W(2)) dut_b (
    .bck(bck), .rst(rst), .lrck(lrck), .din(din),
    .l_dout(l_dout_b), .r_dout(r_dout_b),
    .l_valid(l_valid_b), .r_valid(r_valid_b), .frame_valid(frame_valid_b)
`ifdef I2S_RX_SLOT_CHECK_EN
    , .slot_err(se_b), .err_cnt(ec_b)
`endif
  );

  always #5 bck = ~bck;

  typedef struct packed {
    logic          lv;
    logic          rv;
    logic          fv;
    logic          se;
    logic [7:0]    ec;
    logic [WW-1:0] l;
    logic [WW-1:0] r;
  } snap_t;

  typedef struct {
    int            chan;
    int            len;
    logic [WW-1:0] data;
  } slot_t;

  int    total = 0;
  int    bad   = 0;
  int    n_cyc;
  int    first_l_i2s;
  logic  lr_a [MAXN];
  logic  dd_a [MAXN];
  snap_t obs_a [2][MAXN];
  snap_t exp_a [2][MAXN];
  slot_t slots [$];

  function automatic snap_t snap(input int d);
    snap_t s;
    if (d == 0) s = {l_valid_a, r_valid_a, frame_valid_a, se_a_w, ec_a_w, l_dout_a, r_dout_a};
    else        s = {l_valid_b, r_valid_b, frame_valid_b, se_b_w, ec_b_w, l_dout_b, r_dout_b};
    return s;
  endfunction

  // Lay out the slot list on the wire. The first pre_len cycles are a
  // partial left slot. fmt 0 places the MSB one cycle after the slot
  // boundary, and fmt 1 places it on the boundary. Three tail cycles on
  // the opposite channel close the last slot.
  task automatic build_wire(input int fmt, input int pre_len);
    int pos;
    int last;
    for (int k = 0; k < MAXN; k++) begin
      lr_a[k] = 1'b0;
      dd_a[k] = 1'($urandom);
    end
    pos  = pre_len;
    last = 0;
    foreach (slots[s]) begin
      for (int t = 0; t < slots[s].len; t++) lr_a[pos + t] = 1'(slots[s].chan);
      for (int j = 0; j < slots[s].len && j < WW; j++) begin
        if (pos + fmt + j < MAXN) dd_a[pos + (fmt == 0 ? 1 : 0) + j] = slots[s].data[WW - 1 - j];
      end
      pos  = pos + slots[s].len;
      last = slots[s].chan;
    end
    for (int t = 0; t < 3; t++) lr_a[pos + t] = (last == 0) ? 1'b1 : 1'b0;
    n_cyc = pos + 3;
  endtask

  task automatic apply_reset;
    @(negedge bck);
    rst = 1'b1;
    repeat (2) @(negedge bck);
    rst = 1'b0;
  endtask

  task automatic run_wire(input int upto);
    for (int k = 0; k < upto; k++) begin
      lrck = lr_a[k];
      din  = dd_a[k];
      @(negedge bck);
      obs_a[0][k] = snap(0);
      obs_a[1][k] = snap(1);
    end
  endtask

  // Reference model for one receiver format over cycles 0..upto-1 of the
  // current wire. Cycle numbering starts at the first posedge after reset.
  // A slot runs from one start to the next. Its word is the first WW din
  // bits of that interval, zero-padded. It appears in the snapshot of the
  // cycle in which the next start happens.
  task automatic model_run(input int fmt_lj, input int d, input int upto);
    int    st[$];
    int    ch[$];
    int    si;
    int    hl;
    int    errc;
    int    cap;
    snap_t cur;
    cap = (d == 0) ? 255 : 3;
    for (int k = 0; k < upto; k++) begin
      int p1;
      int p2;
      p1 = (k >= 1) ? int'(lr_a[k-1]) : 0;
      p2 = (k >= 2) ? int'(lr_a[k-2]) : 0;
      if (fmt_lj != 0) begin
        if (int'(lr_a[k]) != p1) begin st.push_back(k); ch.push_back(int'(lr_a[k])); end
      end else if (k >= 1 && p1 != p2) begin
        st.push_back(k); ch.push_back(p1);
      end
    end
    cur  = '0;
    si   = 1;
    hl   = 0;
    errc = 0;
    for (int k = 0; k < upto; k++) begin
      cur.lv = 1'b0; cur.rv = 1'b0; cur.fv = 1'b0; cur.se = 1'b0;
      if (si < st.size() && st[si] == k) begin
        logic [WW-1:0] w;
        int            len;
        w   = '0;
        len = st[si] - st[si-1];
        for (int j = 0; j < WW; j++) if (j < len) w[WW-1-j] = dd_a[st[si-1] + j];
        if (ch[si-1] == 0) begin
          cur.l = w; cur.lv = 1'b1; hl = 1;
        end else begin
          cur.r = w; cur.rv = 1'b1; cur.fv = (hl != 0); hl = 0;
        end
`ifdef I2S_RX_SLOT_CHECK_EN
        if (len != SW) begin
          cur.se = 1'b1;
          if (errc < cap) errc++;
          cur.ec = 8'(errc);
        end
`endif
        si++;
      end
      exp_a[d][k] = cur;
    end
  endtask

  task automatic frames_1(input logic [WW-1:0] ld, input logic [WW-1:0] rd);
    slots.delete();
    slots.push_back('{1, 32, WW'($urandom)});
    for (int f = 0; f < 3; f++) begin
      slots.push_back('{0, 32, ld});
      slots.push_back('{1, 32, rd});
    end
  endtask

  task automatic test_reset;
    snap_t z;
    z = '0;
    #1 rst = 1'b1;
    #1;
    total++; if (snap(0) !== z) begin bad++; $display("FAIL reset_async_a got=%h exp=%h", snap(0), z); end
    total++; if (snap(1) !== z) begin bad++; $display("FAIL reset_async_b got=%h exp=%h", snap(1), z); end
    repeat (3) @(negedge bck);
    total++; if (snap(0) !== z) begin bad++; $display("FAIL reset_hold_a got=%h exp=%h", snap(0), z); end
    total++; if (snap(1) !== z) begin bad++; $display("FAIL reset_hold_b got=%h exp=%h", snap(1), z); end
    rst = 1'b0;
    repeat (4) begin
      @(negedge bck);
      total++; if (snap(0) !== z) begin bad++; $display("FAIL reset_idle_a got=%h exp=%h", snap(0), z); end
    end
  endtask

  task automatic test_i2s;
    int fcnt;
    int lcnt;
    frames_1(24'h123456, 24'hABCDEF);
    build_wire(0, 4);
    apply_reset();
    run_wire(n_cyc);
    model_run(0, 0, n_cyc);
    model_run(1, 1, n_cyc);
    for (int d = 0; d < 2; d++) for (int k = 0; k < n_cyc; k++) begin
      total++;
      if (obs_a[d][k] !== exp_a[d][k]) begin bad++; $display("FAIL i2s dut%0d cyc%0d got=%h exp=%h", d, k, obs_a[d][k], exp_a[d][k]); end
    end
    fcnt = 0; lcnt = 0; first_l_i2s = -1;
    for (int k = 0; k < n_cyc; k++) begin
      if (obs_a[0][k].fv && obs_a[0][k].rv) fcnt++;
      if (obs_a[0][k].lv) begin lcnt++; if (first_l_i2s < 0) first_l_i2s = k; end
    end
    total++; if (obs_a[0][n_cyc-1].l !== 24'h123456) begin bad++; $display("FAIL i2s_left got=%h exp=123456", obs_a[0][n_cyc-1].l); end
    total++; if (obs_a[0][n_cyc-1].r !== 24'hABCDEF) begin bad++; $display("FAIL i2s_right got=%h exp=abcdef", obs_a[0][n_cyc-1].r); end
    total++; if (fcnt != 3) begin bad++; $display("FAIL i2s_frames got=%0d exp=3", fcnt); end
    total++; if (lcnt != 3) begin bad++; $display("FAIL i2s_lvalids got=%0d exp=3", lcnt); end
  endtask

  task automatic test_lj;
    int first_l;
    frames_1(24'h123456, 24'hABCDEF);
    build_wire(1, 4);
    apply_reset();
    run_wire(n_cyc);
    model_run(0, 0, n_cyc);
    model_run(1, 1, n_cyc);
    for (int d = 0; d < 2; d++) for (int k = 0; k < n_cyc; k++) begin
      total++;
      if (obs_a[d][k] !== exp_a[d][k]) begin bad++; $display("FAIL lj dut%0d cyc%0d got=%h exp=%h", d, k, obs_a[d][k], exp_a[d][k]); end
    end
    first_l = -1;
    for (int k = n_cyc - 1; k >= 0; k--) if (obs_a[1][k].lv) first_l = k;
    total++; if (obs_a[1][n_cyc-1].l !== 24'h123456) begin bad++; $display("FAIL lj_left got=%h exp=123456", obs_a[1][n_cyc-1].l); end
    total++; if (obs_a[1][n_cyc-1].r !== 24'hABCDEF) begin bad++; $display("FAIL lj_right got=%h exp=abcdef", obs_a[1][n_cyc-1].r); end
    total++; if (first_l != first_l_i2s - 1) begin bad++; $display("FAIL lj_earlier got=%0d exp=%0d", first_l, first_l_i2s - 1); end
  endtask

  task automatic test_short_slot;
    int secnt;
    slots.delete();
    slots.push_back('{1, 16, WW'($urandom)});
    for (int f = 0; f < 2; f++) begin
      slots.push_back('{0, 16, 24'hBEEF00});
      slots.push_back('{1, 16, 24'hCAFE00});
    end
    build_wire(0, 4);
    apply_reset();
    run_wire(n_cyc);
    model_run(0, 0, n_cyc);
    model_run(1, 1, n_cyc);
    for (int d = 0; d < 2; d++) for (int k = 0; k < n_cyc; k++) begin
      total++;
      if (obs_a[d][k] !== exp_a[d][k]) begin bad++; $display("FAIL short dut%0d cyc%0d got=%h exp=%h", d, k, obs_a[d][k], exp_a[d][k]); end
    end
    total++; if (obs_a[0][n_cyc-1].l !== 24'hBEEF00) begin bad++; $display("FAIL short_left got=%h exp=beef00", obs_a[0][n_cyc-1].l); end
    secnt = 0;
    for (int k = 0; k < n_cyc; k++) if (obs_a[0][k].se) secnt++;
`ifdef I2S_RX_SLOT_CHECK_EN
    total++; if (secnt != 5) begin bad++; $display("FAIL short_slot_err got=%0d exp=5", secnt); end
`else
    total++; if (secnt != 0) begin bad++; $display("FAIL short_slot_err got=%0d exp=0", secnt); end
`endif
  endtask

  task automatic test_first_frame;
    int fa;
    int fb;
    slots.delete();
    slots.push_back('{1, 32, WW'($urandom)});
    slots.push_back('{0, 32, WW'($urandom)});
    slots.push_back('{1, 32, WW'($urandom)});
    build_wire(0, 5);
    apply_reset();
    run_wire(n_cyc);
    model_run(0, 0, n_cyc);
    model_run(1, 1, n_cyc);
    for (int d = 0; d < 2; d++) for (int k = 0; k < n_cyc; k++) begin
      total++;
      if (obs_a[d][k] !== exp_a[d][k]) begin bad++; $display("FAIL first dut%0d cyc%0d got=%h exp=%h", d, k, obs_a[d][k], exp_a[d][k]); end
    end
    fa = -1; fb = -1;
    for (int k = n_cyc - 1; k >= 0; k--) begin
      if (obs_a[0][k].lv || obs_a[0][k].rv) fa = k;
      if (obs_a[1][k].lv || obs_a[1][k].rv) fb = k;
    end
    // lrck edges at cycles 5 and 37: the first one only opens a slot.
    total++; if (fb != 37) begin bad++; $display("FAIL first_valid_lj got=%0d exp=37", fb); end
    total++; if (fa != 38) begin bad++; $display("FAIL first_valid_i2s got=%0d exp=38", fa); end
  endtask

  task automatic test_reset_mid;
    snap_t z;
    z = '0;
    frames_1(24'h123456, 24'hABCDEF);
    build_wire(0, 4);
    apply_reset();
    run_wire(110);
    model_run(0, 0, 110);
    model_run(1, 1, 110);
    for (int d = 0; d < 2; d++) for (int k = 0; k < 110; k++) begin
      total++;
      if (obs_a[d][k] !== exp_a[d][k]) begin bad++; $display("FAIL midpre dut%0d cyc%0d got=%h exp=%h", d, k, obs_a[d][k], exp_a[d][k]); end
    end
    rst = 1'b1;
    #1;
    total++; if (snap(0) !== z) begin bad++; $display("FAIL mid_clear_a got=%h exp=%h", snap(0), z); end
    total++; if (snap(1) !== z) begin bad++; $display("FAIL mid_clear_b got=%h exp=%h", snap(1), z); end
    repeat (2) @(negedge bck);
    rst = 1'b0;
    run_wire(n_cyc);
    model_run(0, 0, n_cyc);
    model_run(1, 1, n_cyc);
    for (int d = 0; d < 2; d++) for (int k = 0; k < n_cyc; k++) begin
      total++;
      if (obs_a[d][k] !== exp_a[d][k]) begin bad++; $display("FAIL midpost dut%0d cyc%0d got=%h exp=%h", d, k, obs_a[d][k], exp_a[d][k]); end
    end
    total++; if (obs_a[0][n_cyc-1].l !== 24'h123456) begin bad++; $display("FAIL mid_left got=%h exp=123456", obs_a[0][n_cyc-1].l); end
    total++; if (obs_a[0][n_cyc-1].r !== 24'hABCDEF) begin bad++; $display("FAIL mid_right got=%h exp=abcdef", obs_a[0][n_cyc-1].r); end
  endtask

  task automatic test_err_sat;
    int ca;
    int cb;
    slots.delete();
    for (int s = 0; s < 6; s++) slots.push_back('{(s % 2 == 0) ? 1 : 0, 31, WW'($urandom)});
    build_wire(0, 3);
    apply_reset();
    run_wire(n_cyc);
    model_run(0, 0, n_cyc);
    model_run(1, 1, n_cyc);
    for (int d = 0; d < 2; d++) for (int k = 0; k < n_cyc; k++) begin
      total++;
      if (obs_a[d][k] !== exp_a[d][k]) begin bad++; $display("FAIL errsat dut%0d cyc%0d got=%h exp=%h", d, k, obs_a[d][k], exp_a[d][k]); end
    end
    ca = 0; cb = 0;
    for (int k = 0; k < n_cyc; k++) begin
      if (obs_a[0][k].lv || obs_a[0][k].rv) ca++;
      if (obs_a[1][k].se) cb++;
    end
    total++; if (ca != 6) begin bad++; $display("FAIL errsat_commits got=%0d exp=6", ca); end
`ifdef I2S_RX_SLOT_CHECK_EN
    total++; if (cb != 6) begin bad++; $display("FAIL errsat_pulses got=%0d exp=6", cb); end
    total++; if (obs_a[1][n_cyc-1].ec !== 8'd3) begin bad++; $display("FAIL errsat_cnt got=%0d exp=3", obs_a[1][n_cyc-1].ec); end
    total++; if (obs_a[0][n_cyc-1].ec !== 8'd6) begin bad++; $display("FAIL errsat_cnt8 got=%0d exp=6", obs_a[0][n_cyc-1].ec); end
`else
    total++; if (cb != 0) begin bad++; $display("FAIL errsat_pulses got=%0d exp=0", cb); end
`endif
  endtask

  task automatic test_back_to_back;
    for (int it = 0; it < 4; it++) begin
      int fmt;
      fmt = int'($urandom_range(0, 1));
      slots.delete();
      for (int s = 0; s < 12; s++) begin
        int r;
        int len;
        r   = int'($urandom_range(0, 9));
        len = (r == 0) ? 1 : (r == 1) ? 2 : int'($urandom_range(16, 40));
        slots.push_back('{(s % 2 == 0) ? 1 : 0, len, WW'($urandom)});
      end
      build_wire(fmt, int'($urandom_range(1, 5)));
      apply_reset();
      run_wire(n_cyc);
      model_run(0, 0, n_cyc);
      model_run(1, 1, n_cyc);
      for (int d = 0; d < 2; d++) for (int k = 0; k < n_cyc; k++) begin
        total++;
        if (obs_a[d][k] !== exp_a[d][k]) begin bad++; $display("FAIL rand%0d dut%0d cyc%0d got=%h exp=%h", it, d, k, obs_a[d][k], exp_a[d][k]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_i2s();
    test_lj();
    test_short_slot();
    test_first_frame();
    test_reset_mid();
    test_err_sat();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
